// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Definitions shared by the asynchronous FIFO and its read-side word packer.
//   FIFO_DATA_WIDTH : default width of one FIFO entry
//   FIFO_PACK_RATIO : default number of FIFO entries packed per wide word
//   out_state_e     : occupancy of the packer output register
//   clog2           : ceiling log2, usable in constant expressions
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_PACK_RATIO = 4;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Number of bits needed to count 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage : fifo_pkg

// File: rtl/pack_out_reg.sv
// -----------------------------------------------------------------------------
// pack_out_reg
// Output register of the word packer together with its two-state occupancy
// machine and the valid/ready handshake towards the sink.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   load_i  : capture data_i/keep_i this edge (only asserted while free_o=1)
//   data_i  : packed word to capture
//   keep_i  : lane mask to capture
//   ready_i : sink ready
//   data_o  : registered packed word
//   keep_o  : registered lane mask
//   valid_o : register holds a word for the sink
//   free_o  : register can take a new word this edge (empty, or draining now)
// -----------------------------------------------------------------------------
module pack_out_reg
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [KEEP_W-1:0] keep_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [KEEP_W-1:0] keep_o,
    output logic              valid_o,
    output logic              free_o
);

    out_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [KEEP_W-1:0] keep_q, keep_d;

    assign valid_o = (state_q == OUT_FULL);
    assign free_o  = (state_q == OUT_EMPTY) | ready_i;
    assign data_o  = data_q;
    assign keep_o  = keep_q;

    // A load always wins, so a handshake and a new word on the same edge keep
    // the register full without a bubble.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        keep_d  = keep_q;
        if (load_i) begin
            state_d = OUT_FULL;
            data_d  = data_i;
            keep_d  = keep_i;
        end else if (valid_o && ready_i) begin
            state_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= OUT_EMPTY;
            data_q  <= '0;
            keep_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
        end
    end

endmodule : pack_out_reg

// File: rtl/fifo_word_packer.sv
// -----------------------------------------------------------------------------
// fifo_word_packer
// Pops narrow entries from a first-word-fall-through FIFO read port and packs
// RATIO of them, little-endian, into one wide word on a valid/ready stream.
// An assembly register plus an output register give one pop per clock while
// the sink keeps accepting.
//   clk_read   : read-domain clock
//   rst_n      : asynchronous active-low reset
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO head entry, valid while fifo_empty=0
//   fifo_read  : combinational pop strobe, never high while fifo_empty=1
//   flush      : (FIFO_PACK_FLUSH_EN only) request to emit a partial word
//   m_data     : packed word, lane 0 holds the first popped entry
//   m_keep     : per-lane valid mask
//   m_valid    : m_data/m_keep valid
//   m_ready    : sink accepts on an edge with m_valid=1
// Optional feature macro: FIFO_PACK_FLUSH_EN adds the flush port and the
// pending-flush register; without it m_keep is all ones on every word.
// -----------------------------------------------------------------------------
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter  int IN_WIDTH  = FIFO_DATA_WIDTH,
    parameter  int RATIO     = FIFO_PACK_RATIO,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
    input  logic                 clk_read,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    output logic                 fifo_read,
`ifdef FIFO_PACK_FLUSH_EN
    input  logic                 flush,
`endif
    output logic [OUT_WIDTH-1:0] m_data,
    output logic [RATIO-1:0]     m_keep,
    output logic                 m_valid,
    input  logic                 m_ready
);

    localparam int              CNT_W     = clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] asm_q, asm_d;
    logic [OUT_WIDTH-1:0] asm_ins;
    logic [OUT_WIDTH-1:0] load_data;
    logic [RATIO-1:0]     load_keep;
    logic                 at_last;
    logic                 out_free;
    logic                 stall;
    logic                 pop;
    logic                 load;

    assign at_last = (cnt_q == LAST_LANE);

    // The assembly register with the current head entry dropped into lane cnt.
    always_comb begin
        asm_ins = asm_q;
        asm_ins[int'(cnt_q) * IN_WIDTH +: IN_WIDTH] = fifo_data;
    end

    assign fifo_read = rst_n & ~fifo_empty & ~stall;
    assign pop       = fifo_read;
    assign load_data = pop ? asm_ins : asm_q;

`ifdef FIFO_PACK_FLUSH_EN
    logic             flush_pend_q, flush_pend_d;
    logic             flush_req;
    logic             partial;
    logic [CNT_W:0]   filled;

    assign flush_req = flush | flush_pend_q;

    // Only the final lane normally waits for the output; a pending partial
    // word also freezes assembly so later entries cannot slip into it.
    assign stall = (at_last & ~out_free) | (flush_req & (cnt_q != '0) & ~out_free);

    // A final-lane pop already yields a full word, so the flush folds into it.
    assign partial      = flush_req & ((cnt_q != '0) | pop) & ~(pop & at_last);
    assign load         = (pop & at_last) | (partial & out_free);
    assign flush_pend_d = partial & ~out_free;
    assign filled       = {1'b0, cnt_q} + (CNT_W + 1)'(pop);

    always_comb begin
        load_keep = '0;
        for (int k = 0; k < RATIO; k++) begin
            load_keep[k] = (int'(filled) > k);
        end
    end

    always_ff @(posedge clk_read or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_d;
        end
    end
`else
    assign stall     = at_last & ~out_free;
    assign load      = pop & at_last;
    assign load_keep = '1;
`endif

    // Emitting a word clears the assembly register so partial words come out
    // with their unused lanes at zero.
    always_comb begin
        cnt_d = cnt_q;
        asm_d = asm_q;
        if (load) begin
            cnt_d = '0;
            asm_d = '0;
        end else if (pop) begin
            cnt_d = cnt_q + CNT_W'(1);
            asm_d = asm_ins;
        end
    end

    always_ff @(posedge clk_read or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
        end
    end

    pack_out_reg #(
        .DATA_W (OUT_WIDTH),
        .KEEP_W (RATIO)
    ) u_out (
        .clk_i   (clk_read),
        .rst_ni  (rst_n),
        .load_i  (load),
        .data_i  (load_data),
        .keep_i  (load_keep),
        .ready_i (m_ready),
        .data_o  (m_data),
        .keep_o  (m_keep),
        .valid_o (m_valid),
        .free_o  (out_free)
    );

endmodule : fifo_word_packer

// File: tb/tb_fifo_word_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_word_packer
// Self-checking bench for fifo_word_packer with the default RATIO=4, 8-bit
// entries. A queue stands in for the FIFO; popped entries are grouped four at a
// time into expected words which the DUT output must present in order.
// -----------------------------------------------------------------------------
module tb_fifo_word_packer;

    localparam int RATIO = 4;

    logic        clk_read = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_read;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_ready;
`ifdef FIFO_PACK_FLUSH_EN
    logic        flush;
`endif

    logic [7:0]  srcQ[$];
    logic [7:0]  lanes[$];
    logic [31:0] expQ[$];
    logic [3:0]  expKeepQ[$];
    logic [31:0] rxQ[$];
    logic        gate;
    int          checks;
    int          passed;
    int          popCount;
    int          readWhileEmpty;

    always #5 clk_read = ~clk_read;

    fifo_word_packer dut (
        .clk_read   (clk_read),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
`ifdef FIFO_PACK_FLUSH_EN
        .flush      (flush),
`endif
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    // One clock cycle: present FIFO head, check outputs against the model,
    // then advance the model with whatever happened on the edge.
    task automatic tick();
        logic        expRead;
        logic        popNow;
        logic        hsNow;
        logic [31:0] dataNow;
        logic [31:0] w;
        logic        flushNow;
        fifo_empty = !(gate && srcQ.size() > 0);
        fifo_data  = (srcQ.size() > 0) ? srcQ[0] : 8'($urandom);
        flushNow   = 1'b0;
`ifdef FIFO_PACK_FLUSH_EN
        flushNow   = flush;
`endif
        #1;
        expRead = !fifo_empty && !(lanes.size() == RATIO - 1 && expQ.size() > 0 && !m_ready);
        if (fifo_read && fifo_empty) readWhileEmpty++;
        checks++;
        if (fifo_read !== expRead) $display("[TB] FAIL fifo_read: got %b expected %b (lanes %0d)", fifo_read, expRead, lanes.size());
        else passed++;
        checks++;
        if (m_valid !== (expQ.size() > 0)) $display("[TB] FAIL m_valid: got %b expected %b", m_valid, expQ.size() > 0);
        else passed++;
        if (expQ.size() > 0) begin
            checks++;
            if (m_data !== expQ[0]) $display("[TB] FAIL m_data: got %h expected %h", m_data, expQ[0]);
            else passed++;
            checks++;
            if (m_keep !== expKeepQ[0]) $display("[TB] FAIL m_keep: got %h expected %h", m_keep, expKeepQ[0]);
            else passed++;
        end
        popNow  = fifo_read && !fifo_empty;
        hsNow   = m_valid && m_ready;
        dataNow = m_data;
        @(posedge clk_read);
        if (hsNow) begin
            rxQ.push_back(dataNow);
            if (expQ.size() > 0) begin
                void'(expQ.pop_front());
                void'(expKeepQ.pop_front());
            end
        end
        if (popNow) begin
            popCount++;
            lanes.push_back(srcQ.pop_front());
            if (lanes.size() == RATIO) begin
                w = '0;
                for (int k = 0; k < RATIO; k++) w = w | (32'(lanes[k]) << (8 * k));
                expQ.push_back(w);
                expKeepQ.push_back(4'hF);
                lanes.delete();
            end
        end
        if (flushNow && lanes.size() > 0) begin
            w = '0;
            for (int k = 0; k < lanes.size(); k++) w = w | (32'(lanes[k]) << (8 * k));
            expQ.push_back(w);
            expKeepQ.push_back(4'((1 << lanes.size()) - 1));
            lanes.delete();
        end
        @(negedge clk_read);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        gate    = 1'b1;
        m_ready = 1'b1;
        while ((srcQ.size() > 0 || expQ.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) $display("[TB] FAIL drain_timeout: got %0d cycles required < %0d", n, budget);
        else passed++;
    endtask

    task automatic assertReset();
        rst_n      = 1'b0;
        fifo_empty = 1'b0;
        fifo_data  = 8'h5A;
        #1;
        checks++;
        if (fifo_read !== 1'b0) $display("[TB] FAIL reset_fifo_read: got %b expected 0", fifo_read);
        else passed++;
        checks++;
        if (m_valid !== 1'b0) $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid);
        else passed++;
        checks++;
        if (m_data !== 32'h0) $display("[TB] FAIL reset_m_data: got %h expected 00000000", m_data);
        else passed++;
        checks++;
        if (m_keep !== 4'h0) $display("[TB] FAIL reset_m_keep: got %h expected 0", m_keep);
        else passed++;
        lanes.delete();
        expQ.delete();
        expKeepQ.delete();
        srcQ.delete();
        repeat (2) @(negedge clk_read);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_read);
        assertReset();
    endtask

    task automatic test_single_word();
        rxQ.delete();
        srcQ = '{8'h11, 8'h22, 8'h33, 8'h44};
        drain(20);
        checks++;
        if (rxQ.size() != 1 || rxQ[0] !== 32'h44332211) $display("[TB] FAIL single_word: got %0d words first %h expected 44332211", rxQ.size(), (rxQ.size() > 0) ? rxQ[0] : 32'h0);
        else passed++;
    endtask

    task automatic test_stream();
        int pops0;
        rxQ.delete();
        for (int i = 0; i < 16; i++) srcQ.push_back(8'(i));
        pops0 = popCount;
        gate = 1'b1;
        m_ready = 1'b1;
        repeat (16) tick();
        checks++;
        if (popCount - pops0 != 16) $display("[TB] FAIL stream_pops: got %0d expected 16", popCount - pops0);
        else passed++;
        drain(20);
        checks++;
        if (rxQ.size() != 4 || rxQ[0] !== 32'h03020100 || rxQ[1] !== 32'h07060504 || rxQ[2] !== 32'h0B0A0908 || rxQ[3] !== 32'h0F0E0D0C)
            $display("[TB] FAIL stream_words: got %0d words expected 4 in order 03020100..0F0E0D0C", rxQ.size());
        else passed++;
    endtask

    task automatic test_back_pressure();
        int pops0;
        rxQ.delete();
        for (int i = 0; i < 8; i++) srcQ.push_back(8'h80 + 8'(i));
        pops0 = popCount;
        gate = 1'b1;
        m_ready = 1'b0;
        repeat (12) tick();
        checks++;
        if (popCount - pops0 != 7) $display("[TB] FAIL stall_pops: got %0d expected 7", popCount - pops0);
        else passed++;
        m_ready = 1'b1;
        tick();
        checks++;
        if (popCount - pops0 != 8) $display("[TB] FAIL handshake_pop: got %0d expected 8", popCount - pops0);
        else passed++;
        drain(20);
        checks++;
        if (rxQ.size() != 2 || rxQ[0] !== 32'h83828180 || rxQ[1] !== 32'h87868584) $display("[TB] FAIL back_pressure_words: got %0d words expected 83828180,87868584", rxQ.size());
        else passed++;
    endtask

    task automatic test_empty_toggle();
        int n;
        rxQ.delete();
        readWhileEmpty = 0;
        srcQ = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        m_ready = 1'b1;
        n = 0;
        while ((srcQ.size() > 0 || expQ.size() > 0) && n < 40) begin
            gate = n[0];
            tick();
            n++;
        end
        checks++;
        if (n >= 40 || rxQ.size() != 1 || rxQ[0] !== 32'hA3A2A1A0) $display("[TB] FAIL empty_toggle_word: got %0d words expected A3A2A1A0", rxQ.size());
        else passed++;
        checks++;
        if (readWhileEmpty != 0) $display("[TB] FAIL read_while_empty: got %0d expected 0", readWhileEmpty);
        else passed++;
    endtask

    task automatic test_reset_midword();
        rxQ.delete();
        srcQ = '{8'hDE, 8'hAD};
        gate = 1'b1;
        m_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (lanes.size() != 2) $display("[TB] FAIL midword_pops: got %0d expected 2", lanes.size());
        else passed++;
        assertReset();
        srcQ = '{8'h01, 8'h02, 8'h03, 8'h04};
        drain(20);
        checks++;
        if (rxQ.size() != 1 || rxQ[0] !== 32'h04030201) $display("[TB] FAIL reset_midword_word: got %0d words first %h expected 04030201", rxQ.size(), (rxQ.size() > 0) ? rxQ[0] : 32'h0);
        else passed++;
    endtask

    task automatic test_random();
        rxQ.delete();
        for (int i = 0; i < 48; i++) srcQ.push_back(8'($urandom));
        for (int c = 0; c < 300 && srcQ.size() > 0; c++) begin
            gate    = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain(60);
        checks++;
        if (rxQ.size() != 12) $display("[TB] FAIL random_word_count: got %0d expected 12", rxQ.size());
        else passed++;
    endtask

`ifdef FIFO_PACK_FLUSH_EN
    task automatic test_flush();
        rxQ.delete();
        srcQ = '{8'hAA, 8'hBB};
        gate = 1'b1;
        m_ready = 1'b1;
        repeat (2) tick();
        gate = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        checks++;
        if (rxQ.size() != 1 || rxQ[0] !== 32'h0000BBAA) $display("[TB] FAIL flush_partial: got %0d words expected 0000BBAA", rxQ.size());
        else passed++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (2) tick();
        checks++;
        if (rxQ.size() != 1) $display("[TB] FAIL flush_empty: got %0d words expected 1", rxQ.size());
        else passed++;
    endtask
`endif

    initial begin
        checks   = 0;
        passed   = 0;
        popCount = 0;
        readWhileEmpty = 0;
        rst_n    = 1'b0;
        gate     = 1'b0;
        m_ready  = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
`ifdef FIFO_PACK_FLUSH_EN
        flush    = 1'b0;
`endif
        test_reset();
        test_single_word();
        test_stream();
        test_back_pressure();
        test_empty_toggle();
        test_reset_midword();
        test_random();
`ifdef FIFO_PACK_FLUSH_EN
        test_flush();
`endif
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_fifo_word_packer
